// File: rtl/debounce_sync.sv
// Two-flop-style synchronizer followed by a counter-based debounce FSM for one async bit.
// Optional registered rise/fall pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_sync #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // cnt counts the equal samples already seen; the STABLE_CYCLES-th one commits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // level only moves on a committed transition, so its next-state edge is the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= level_d & ~level_q;
      fall_q <= ~level_d & level_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: a 2/4 instance driven from a vector table plus
// hand sequences for reset corners, and a default 2/16 instance for latency checks.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic lvl4, rise4, fall4;
  logic lvl16, rise16, fall16;

  int checks = 0;
  int failures = 0;

`ifdef DEBOUNCE_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  always #5 clk = ~clk;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) u_s4 (
    .clk(clk), .rst(rst), .din(din), .level(lvl4), .rise(rise4), .fall(fall4)
  );

  debounce_sync u_d16 (
    .clk(clk), .rst(rst), .din(din), .level(lvl16), .rise(rise16), .fall(fall16)
  );

  typedef struct packed {
    logic       rst;
    logic       din;
    logic [2:0] exp;   // {level, rise, fall}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] ex(input logic l, input logic rs, input logic fl);
    return {l, rs & EDGE, fl & EDGE};
  endfunction

  function automatic void add(input int n, input logic r, input logic d,
                              input logic l, input logic rs, input logic fl);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = r;
      v.din = d;
      v.exp = ex(l, rs, fl);
      tbl.push_back(v);
    end
  endfunction

  // Drive inputs mid-cycle, then check outputs 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic d, input bit big,
                      input logic [2:0] exp, input string nm, input int idx);
    logic [2:0] act;
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
    act = big ? {lvl16, rise16, fall16} : {lvl4, rise4, fall4};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] level/rise/fall got=%b expected=%b", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Scenario 1: reset with din low, then a clean rise (commits 6 edges after din goes high).
    add(3, 1, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(2, 0, 1, 1, 0, 0);
    // Return low cleanly: fall on the 6th edge.
    add(5, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1);
    add(2, 0, 0, 0, 0, 0);
    // Scenario 2: bounce 1,1,0,0,1,1,0,0 then hold 1; rise 6 edges after the final 1 starts.
    add(2, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(2, 0, 1, 1, 0, 0);
    // Scenario 3: 3-cycle low glitch is rejected.
    add(3, 0, 0, 1, 0, 0);
    add(5, 0, 1, 1, 0, 0);
    // 4-cycle low is accepted; din back to 1 gives a rise exactly 4 cycles after the fall.
    add(4, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 1, 0, 0);

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].din, 1'b0, tbl[i].exp, "tbl", i);

    // Scenario 4: reset while in WAIT_HI with cnt=2, din stays high.
    for (int i = 0; i < 2; i++) step(1, 0, 1'b0, ex(0, 0, 0), "s4_rst", i);
    for (int i = 0; i < 4; i++) step(0, 1, 1'b0, ex(0, 0, 0), "s4_cnt", i);
    step(1, 1, 1'b0, ex(0, 0, 0), "s4_midrst", 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1'b0, ex(0, 0, 0), "s4_wait", i);
    step(0, 1, 1'b0, ex(1, 1, 0), "s4_rise", 0);
    step(0, 1, 1'b0, ex(1, 0, 0), "s4_after", 0);

    // Reset on the very edge that would commit the rise: reset wins, no pulse.
    for (int i = 0; i < 2; i++) step(1, 0, 1'b0, ex(0, 0, 0), "s4b_rst", i);
    for (int i = 0; i < 5; i++) step(0, 1, 1'b0, ex(0, 0, 0), "s4b_cnt", i);
    step(1, 1, 1'b0, ex(0, 0, 0), "s4b_collide", 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1'b0, ex(0, 0, 0), "s4b_wait", i);
    step(0, 1, 1'b0, ex(1, 1, 0), "s4b_rise", 0);

    // Scenario 5: default 2/16 instance; step commits at edge 18 and not before.
    for (int i = 0; i < 2; i++) step(1, 0, 1'b1, ex(0, 0, 0), "s5_rst", i);
    for (int i = 0; i < 17; i++) step(0, 1, 1'b1, ex(0, 0, 0), "s5_wait", i);
    step(0, 1, 1'b1, ex(1, 1, 0), "s5_rise", 0);
    step(0, 1, 1'b1, ex(1, 0, 0), "s5_after", 0);
    // 15-cycle low excursion is rejected.
    for (int i = 0; i < 15; i++) step(0, 0, 1'b1, ex(1, 0, 0), "s5_excl", i);
    for (int i = 0; i < 20; i++) step(0, 1, 1'b1, ex(1, 0, 0), "s5_exch", i);
    // Full 16-cycle low is accepted at edge 18.
    for (int i = 0; i < 17; i++) step(0, 0, 1'b1, ex(1, 0, 0), "s5_fwait", i);
    step(0, 0, 1'b1, ex(0, 0, 1), "s5_fall", 0);
    step(0, 0, 1'b1, ex(0, 0, 0), "s5_fafter", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
